// File: rtl/mips_instr_feeder.sv
// Instruction-side feeder for the multicycle MIPS controller: program store, fetch/retire tracking, hang detect.
// Optional CPI statistics (cyc_total, max_cpi) are built when CPI_STATS_EN is defined.
module mips_instr_feeder #(
  parameter int ADDR_W  = 4,
  parameter int MAX_CPI = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [12:0]       ld_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              irwrite,
  input  logic              pcen,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   retired,
  output logic [31:0]       cyc_total,
  output logic [3:0]        max_cpi
);

  localparam int GAP_W = $clog2(MAX_CPI + 1);
  localparam logic [GAP_W:0] CPI_LIMIT = MAX_CPI[GAP_W:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE, HANG} state_t;

  state_t            state, state_next;
  logic [12:0]       mem [2**ADDR_W];
  logic [ADDR_W:0]   ptr, len;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W:0]    gap_inc;
  logic              in_run, start_ok, more, hang_hit;
  logic              unused_pcen;

  // pcen carries no information the feeder needs; every PC update is legal.
  assign unused_pcen = pcen;

  assign in_run   = (state == RUN);
  assign start_ok = start && !in_run;
  assign more     = (ptr < len);
  assign gap_inc  = {1'b0, gap} + {{GAP_W{1'b0}}, 1'b1};
  assign hang_hit = in_run && !irwrite && (gap_inc == CPI_LIMIT);
  assign busy     = in_run;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (irwrite && !more) state_next = DONE;
        else if (hang_hit)    state_next = HANG;
      end
      default: begin
        if (start) state_next = (prog_len != '0) ? RUN : DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && ld_en && !in_run) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op      <= '0;
      funct   <= '0;
      zero    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      retired <= '0;
      ptr     <= '0;
      len     <= '0;
      gap     <= '0;
    end else if (in_run) begin
      if (irwrite) begin
        if (more) begin
          {op, funct, zero} <= mem[ptr[ADDR_W-1:0]];
          ptr <= ptr + {{ADDR_W{1'b0}}, 1'b1};
          gap <= '0;
        end else begin
          done <= 1'b1;
        end
        if (ptr != '0) retired <= retired + {{ADDR_W{1'b0}}, 1'b1};
      end else if (hang_hit) begin
        timeout <= 1'b1;
      end else begin
        gap <= gap_inc[GAP_W-1:0];
      end
    end else if (start_ok) begin
      timeout <= 1'b0;
      if (prog_len != '0) begin
        ptr     <= '0;
        len     <= prog_len;
        retired <= '0;
        gap     <= '0;
        done    <= 1'b0;
        op      <= '0;
        funct   <= '0;
        zero    <= 1'b0;
      end else begin
        done <= 1'b1;
      end
    end
  end

`ifdef CPI_STATS_EN
  logic [31:0] cyc_q;
  logic [3:0]  max_q;
  logic [3:0]  cpi_now;

  // The instruction just retired spanned gap+1 cycles; clamp to the 4-bit output.
  always_comb begin
    cpi_now = (32'(gap_inc) > 32'd15) ? 4'd15 : 4'(gap_inc);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q <= '0;
      max_q <= '0;
    end else if (start_ok) begin
      cyc_q <= '0;
      max_q <= '0;
    end else if (in_run) begin
      if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
      if (irwrite && (ptr != '0) && (cpi_now > max_q)) max_q <= cpi_now;
    end
  end

  assign cyc_total = cyc_q;
  assign max_cpi   = max_q;
`else
  assign cyc_total = '0;
  assign max_cpi   = '0;
`endif

endmodule
